// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU beside the ALU, owning the HI/LO registers.
// One product/quotient bit is resolved per cycle on operand magnitudes. Signs are applied in a final FIX cycle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] Rsdata,
   input  logic [WIDTH-1:0] Rtdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t state, state_n;
   logic [CW-1:0] count;
   logic [1:0] op_q;
   logic sign_q, sign_r, dz, go, is_signed;
   logic [WIDTH-1:0] opb, rem, rs_mag, rt_mag, quot, remv;
   logic [2*WIDTH-1:0] acc, prod;
   logic [WIDTH:0] mul_sum, shifted, trial;
   assign busy = state != IDLE;
   assign go = start && !busy && op <= 3'd3;
   assign is_signed = !op[0];
   assign rs_mag = (is_signed && Rsdata[WIDTH-1]) ? -Rsdata : Rsdata;
   assign rt_mag = (is_signed && Rtdata[WIDTH-1]) ? -Rtdata : Rtdata;
   // acc holds {partial product, multiplier} for multiply and the dividend/quotient in its low half for divide
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
   assign shifted = {rem, acc[WIDTH-1]};
   assign trial = shifted - {1'b0, opb};
   assign prod = sign_q ? -acc : acc;
   assign quot = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign remv = sign_r ? -rem : rem;
   always_comb begin
      state_n = state;
      state_n = (state == IDLE) ? (go ? CALC : IDLE) : (state == CALC) ? ((count == '0) ? FIX : CALC) : IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         op_q <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         dz <= 1'b0;
         opb <= '0;
         rem <= '0;
         acc <= '0;
         done <= 1'b0;
         div_by_zero <= 1'b0;
         hi <= '0;
         lo <= '0;
      end else begin
         state <= state_n;
         done <= state == FIX;
         div_by_zero <= state == FIX && op_q[1] && dz;
         if (go) begin
            count <= CW'(WIDTH - 1);
            op_q <= op[1:0];
            sign_q <= is_signed && (Rsdata[WIDTH-1] ^ Rtdata[WIDTH-1]);
            sign_r <= is_signed && Rsdata[WIDTH-1];
            dz <= Rtdata == '0;
            acc <= {{WIDTH{1'b0}}, op[1] ? rs_mag : rt_mag};
            opb <= op[1] ? rt_mag : rs_mag;
            rem <= '0;
         end
         if (state == CALC) begin
            count <= count - CW'(1);
            if (op_q[1]) begin
               rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
               acc[WIDTH-1:0] <= {acc[WIDTH-2:0], !trial[WIDTH]};
            end else
               acc <= {mul_sum, acc[WIDTH-1:1]};
         end
         // a zero divisor leaves the dividend magnitude in rem, so remv restores the original Rsdata
         if (state == FIX)
            {hi, lo} <= op_q[1] ? {remv, dz ? {WIDTH{1'b1}} : quot} : prod;
         else if (start && !busy && op == 3'd4)
            hi <= Rsdata;
         else if (start && !busy && op == 3'd5)
            lo <= Rsdata;
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table vectors, randomized ops against an arithmetic model, and handshake/reset corner sequences.
module tb_mult_div_unit;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [2:0] op = 3'd0;
   logic [31:0] rs = '0, rt = '0;
   logic busy, done, dbz;
   logic [31:0] hi, lo;
   int vectors = 0, miscompares = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .Rsdata(rs), .Rtdata(rt),
      .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [2:0]  o;
      logic [31:0] a, b, eh, el;
      logic        ez;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit integer arithmetic; SV division truncates toward zero like MIPS DIV.
   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic z);
      longint sa, sb;
      logic [63:0] p;
      sa = o[0] ? longint'({32'd0, a}) : longint'($signed(a));
      sb = o[0] ? longint'({32'd0, b}) : longint'($signed(b));
      z = 1'b0;
      if (!o[1]) begin
         p = 64'(sa * sb);
         h = p[63:32];
         l = p[31:0];
      end else if (b == 0) begin
         h = a;
         l = 32'hFFFF_FFFF;
         z = 1'b1;
      end else begin
         l = 32'(sa / sb);
         h = 32'(sa % sb);
      end
   endfunction

   task automatic wait_done(input int k0, input logic [31:0] ph, input logic [31:0] pl,
                            output int k, output int bc, output int herr);
      k = k0;
      bc = 0;
      herr = 0;
      while (done !== 1'b1 && k < 40) begin
         if (busy === 1'b1) bc++;
         if (hi !== ph || lo !== pl || dbz !== 1'b0) herr++;
         @(negedge clk);
         k++;
      end
   endtask

   task automatic do_arith(input bit now, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] h, output logic [31:0] l, output logic z);
      logic [31:0] ph, pl;
      int k, bc, herr;
      if (!now) @(negedge clk);
      ph = hi;
      pl = lo;
      start = 1'b1;
      op = o;
      rs = a;
      rt = b;
      @(negedge clk);
      start = 1'b0;
      rs = $urandom;
      rt = $urandom;
      wait_done(1, ph, pl, k, bc, herr);
      chk("latency", 64'(k), 64'd34);
      chk("busy_cycles", 64'(bc), 64'd33);
      chk("hold_during_calc", 64'(herr), 64'd0);
      chk("busy_at_done", {63'd0, busy}, 64'd0);
      h = hi;
      l = lo;
      z = dbz;
   endtask

   task automatic do_move(input bit now, input logic [2:0] o, input logic [31:0] a);
      if (!now) @(negedge clk);
      start = 1'b1;
      op = o;
      rs = a;
      @(negedge clk);
      start = 1'b0;
      chk("move_busy", {62'd0, busy, done}, 64'd0);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] s [6];
      s = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 32'd7};
      return ($urandom_range(0, 3) == 0) ? s[$urandom_range(0, 5)] : $urandom;
   endfunction

   initial begin
      vec_t tbl [10];
      logic [31:0] h, l, eh, el, mh, ml;
      logic z, ez;
      bit seen;
      int k, bc, herr;
      tbl[0] = '{3'd0, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
      tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      tbl[3] = '{3'd3, 32'd100,       32'd7,          32'd2,         32'd14,         1'b0};
      tbl[4] = '{3'd3, 32'd100,       32'd0,          32'd100,       32'hFFFF_FFFF, 1'b1};
      tbl[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
      tbl[6] = '{3'd2, 32'h8000_0000, 32'd0,          32'h8000_0000, 32'hFFFF_FFFF, 1'b1};
      tbl[7] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
      tbl[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
      tbl[9] = '{3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0};

      repeat (2) @(negedge clk);
      chk("reset_state", {busy, done, dbz, hi, lo}, 67'd0);
      reset = 1'b0;

      // table vectors; after the first, each start lands in the previous done cycle
      for (int i = 0; i < 10; i++) begin
         do_arith(i > 0, tbl[i].o, tbl[i].a, tbl[i].b, h, l, z);
         chk($sformatf("tbl%0d_hi", i), {32'd0, h}, {32'd0, tbl[i].eh});
         chk($sformatf("tbl%0d_lo", i), {32'd0, l}, {32'd0, tbl[i].el});
         chk($sformatf("tbl%0d_dbz", i), {63'd0, z}, {63'd0, tbl[i].ez});
      end
      @(negedge clk);
      chk("done_single_pulse", {62'd0, done, dbz}, 64'd0);

      // randomized mix against the model
      mh = hi;
      ml = lo;
      for (int i = 0; i < 40; i++) begin
         int r;
         logic [31:0] a, b;
         r = $urandom_range(0, 9);
         a = pick();
         b = pick();
         if (r < 8) begin
            do_arith(bit'($urandom_range(0, 1)), 3'(r % 4), a, b, h, l, z);
            model(3'(r % 4), a, b, eh, el, ez);
            mh = eh;
            ml = el;
            chk($sformatf("rnd%0d_op%0d_hilo", i, r % 4), {h, l}, {eh, el});
            chk($sformatf("rnd%0d_dbz", i), {63'd0, z}, {63'd0, ez});
         end else begin
            do_move(bit'($urandom_range(0, 1)), 3'(r - 4), a);
            if (r == 8) mh = a; else ml = a;
            chk($sformatf("rnd%0d_move", i), {hi, lo}, {mh, ml});
         end
      end

      // ops 6/7 do nothing
      do_move(1'b0, 3'd6, 32'h1111_1111);
      do_move(1'b0, 3'd7, 32'h2222_2222);
      @(negedge clk);
      chk("noop_hold", {hi, lo}, {mh, ml});
      chk("noop_idle", {62'd0, busy, done}, 64'd0);

      // MULT 6*7 with DIVU and MTHI requested while busy
      do_move(1'b0, 3'd4, 32'h0);
      do_move(1'b0, 3'd5, 32'h5);
      @(negedge clk);
      start = 1'b1; op = 3'd0; rs = 32'd6; rt = 32'd7;
      @(negedge clk);
      op = 3'd3; rs = 32'd100; rt = 32'd7;
      @(negedge clk);
      op = 3'd4; rs = 32'h1234;
      @(negedge clk);
      start = 1'b0;
      wait_done(3, 32'h0, 32'h5, k, bc, herr);
      chk("busy_ignore_latency", 64'(k), 64'd34);
      chk("busy_ignore_hold", 64'(herr), 64'd0);
      chk("busy_ignore_result", {hi, lo}, {32'h0, 32'd42});
      @(negedge clk);
      chk("no_queued_op", {62'd0, busy, done}, 64'd0);
      do_move(1'b1, 3'd5, 32'hABCD);
      chk("mtlo_after", {hi, lo}, {32'h0, 32'hABCD});

      // async reset in the middle of a DIV
      do_move(1'b0, 3'd4, 32'h55);
      do_move(1'b1, 3'd5, 32'h66);
      start = 1'b1; op = 3'd2; rs = 32'hFFFF_FF9C; rt = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("pre_reset_busy", {31'd0, busy, hi, lo}, {31'd0, 1'b1, 32'h55, 32'h66});
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk("async_reset", {busy, done, dbz, hi, lo}, 67'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy || dbz) seen = 1'b1;
      end
      chk("no_done_after_reset", {63'd0, seen}, 64'd0);
      chk("reset_hilo_hold", {hi, lo}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
